// File: rtl/tea_pkg.sv
// Shared command bytes, reply bytes and FSM state type for the TEA frame front end.
package tea_pkg;

    localparam logic [7:0] CMD_KEY   = 8'h4B;
    localparam logic [7:0] CMD_PLAIN = 8'h50;
    localparam logic [7:0] CMD_CLR   = 8'h43;
    localparam logic [7:0] ACK       = 8'h06;
    localparam logic [7:0] NAK       = 8'h15;

    typedef enum logic [2:0] {
        IDLE,
        RX_KEY,
        RX_PLAIN,
        START,
        WAIT_DONE,
        TX
    } tea_state_e;

    function automatic int tea_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/tea_byte_serializer.sv
// Parallel-load, MSB-first byte serializer with a valid/ready output and a done strobe.
module tea_byte_serializer #(
    parameter int NBYTES = 8,
    localparam int LW = $clog2(NBYTES + 1)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_load,
    input  logic [NBYTES*8-1:0] i_data,
    input  logic [LW-1:0]     i_len,
    input  logic              i_tx_ready,
    output logic [7:0]        o_tx_data,
    output logic              o_tx_valid,
    output logic              o_done
);

    logic [NBYTES*8-1:0] data_q;
    logic [LW-1:0]       left_q;
    logic                fire;

    assign o_tx_valid = (left_q != '0);
    assign o_tx_data  = data_q[NBYTES*8-1 -: 8];
    assign fire       = o_tx_valid & i_tx_ready;
    assign o_done     = fire & (left_q == LW'(1));

    // Load a new block, or shift the top byte out once the receiver takes it.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            data_q <= '0;
            left_q <= '0;
        end else if (i_load) begin
            data_q <= i_data;
            left_q <= i_len;
        end else if (fire) begin
            data_q <= data_q << 8;
            left_q <= left_q - 1'b1;
        end
    end

endmodule

// File: rtl/tea_frame_frontend.sv
// UART frame front end for a TEA cipher core: parses key/plaintext frames,
// starts the core and streams the result back. Optional macro
// TEA_FRONTEND_ACK_EN adds ACK/NAK reply bytes.
module tea_frame_frontend #(
    parameter int KEY_BYTES      = 16,
    parameter int BLOCK_BYTES    = 8,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic [7:0]               i_rx_data,
    input  logic                     i_rx_valid,
    input  logic                     i_done,
    input  logic [BLOCK_BYTES*8-1:0] i_result,
    input  logic                     i_tx_ready,
    output logic [KEY_BYTES*8-1:0]   o_key,
    output logic                     o_key_valid,
    output logic [BLOCK_BYTES*8-1:0] o_plain,
    output logic                     o_start,
    output logic [7:0]               o_tx_data,
    output logic                     o_tx_valid,
    output logic                     o_busy,
    output logic                     o_err
);

    import tea_pkg::*;

`ifdef TEA_FRONTEND_ACK_EN
    localparam bit ACK_EN = 1'b1;
`else
    localparam bit ACK_EN = 1'b0;
`endif

    localparam int MAXB = tea_max(KEY_BYTES, BLOCK_BYTES);
    localparam int SW   = MAXB * 8;
    localparam int BW   = BLOCK_BYTES * 8;
    localparam int CW   = $clog2(MAXB + 1);
    localparam int TW   = $clog2(TIMEOUT_CYCLES + 1);
    localparam int LW   = $clog2(BLOCK_BYTES + 1);

    tea_state_e           state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [TW-1:0]        tmo_q, tmo_d;
    logic [SW-1:0]        shadow_q, shadow_d;
    logic [KEY_BYTES*8-1:0] key_q, key_d;
    logic                 key_valid_q, key_valid_d;
    logic [BW-1:0]        plain_q, plain_d;
    logic                 err_q, err_d;
    logic                 ser_load;
    logic [BW-1:0]        ser_data;
    logic [LW-1:0]        ser_len;
    logic                 ser_done;
    logic                 nak;
    logic                 expired;

    assign o_key       = key_q;
    assign o_key_valid = key_valid_q;
    assign o_plain     = plain_q;
    assign o_err       = err_q;
    assign o_busy      = (state_q != IDLE);
    assign expired     = (tmo_q == TW'(TIMEOUT_CYCLES - 1)) && !i_rx_valid;

    // State and datapath registers; reset drops everything, including a frame in flight.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            tmo_q       <= '0;
            shadow_q    <= '0;
            key_q       <= '0;
            key_valid_q <= 1'b0;
            plain_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            tmo_q       <= tmo_d;
            shadow_q    <= shadow_d;
            key_q       <= key_d;
            key_valid_q <= key_valid_d;
            plain_q     <= plain_d;
            err_q       <= err_d;
        end
    end

    // Frame parser: command decode, byte shifting, commits, timeout and handshake with the core.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        tmo_d       = tmo_q;
        shadow_d    = shadow_q;
        key_d       = key_q;
        key_valid_d = key_valid_q;
        plain_d     = plain_q;
        err_d       = err_q;
        ser_load    = 1'b0;
        ser_data    = '0;
        ser_len     = '0;
        o_start     = 1'b0;
        nak         = 1'b0;

        case (state_q)
            IDLE: begin
                if (i_rx_valid) begin
                    case (i_rx_data)
                        CMD_KEY: begin
                            state_d  = RX_KEY;
                            cnt_d    = '0;
                            tmo_d    = '0;
                            shadow_d = '0;
                        end
                        CMD_PLAIN: begin
                            if (key_valid_q) begin
                                state_d  = RX_PLAIN;
                                cnt_d    = '0;
                                tmo_d    = '0;
                                shadow_d = '0;
                            end else begin
                                err_d = 1'b1;
                                nak   = 1'b1;
                            end
                        end
                        CMD_CLR: err_d = 1'b0;
                        default: begin
                            err_d = 1'b1;
                            nak   = 1'b1;
                        end
                    endcase
                end
            end

            RX_KEY, RX_PLAIN: begin
                if (i_rx_valid) begin
                    shadow_d = (shadow_q << 8) | SW'(i_rx_data);
                    tmo_d    = '0;
                    if (state_q == RX_KEY && cnt_q == CW'(KEY_BYTES - 1)) begin
                        key_d       = shadow_d[KEY_BYTES*8-1:0];
                        key_valid_d = 1'b1;
                        cnt_d       = '0;
                        state_d     = IDLE;
                        if (ACK_EN) begin
                            ser_load = 1'b1;
                            ser_data = BW'(ACK) << (BW - 8);
                            ser_len  = LW'(1);
                            state_d  = TX;
                        end
                    end else if (state_q == RX_PLAIN && cnt_q == CW'(BLOCK_BYTES - 1)) begin
                        plain_d = shadow_d[BW-1:0];
                        cnt_d   = '0;
                        state_d = START;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else if (expired) begin
                    err_d    = 1'b1;
                    nak      = 1'b1;
                    shadow_d = '0;
                    cnt_d    = '0;
                    tmo_d    = '0;
                    state_d  = IDLE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end

            START: begin
                o_start = 1'b1;
                state_d = WAIT_DONE;
                if (i_rx_valid) err_d = 1'b1;
            end

            WAIT_DONE: begin
                if (i_rx_valid) err_d = 1'b1;
                if (i_done) begin
                    ser_load = 1'b1;
                    ser_data = i_result;
                    ser_len  = LW'(BLOCK_BYTES);
                    state_d  = TX;
                end
            end

            TX: begin
                if (i_rx_valid) err_d = 1'b1;
                if (ser_done) state_d = IDLE;
            end

            default: state_d = IDLE;
        endcase

        if (ACK_EN && nak) begin
            ser_load = 1'b1;
            ser_data = BW'(NAK) << (BW - 8);
            ser_len  = LW'(1);
            state_d  = TX;
        end
    end

    tea_byte_serializer #(
        .NBYTES (BLOCK_BYTES)
    ) u_ser (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_load     (ser_load),
        .i_data     (ser_data),
        .i_len      (ser_len),
        .i_tx_ready (i_tx_ready),
        .o_tx_data  (o_tx_data),
        .o_tx_valid (o_tx_valid),
        .o_done     (ser_done)
    );

endmodule

// File: tb/tb_tea_frame_frontend.sv
// Directed self-checking bench for tea_frame_frontend (default build, short timeout).
module tb_tea_frame_frontend;

    localparam int KB = 16;
    localparam int BB = 8;
    localparam int TO = 50;

    logic           clk = 1'b0;
    logic           rstN;
    logic [7:0]     rxData;
    logic           rxValid;
    logic           done;
    logic [BB*8-1:0] result;
    logic           txReady;
    logic [KB*8-1:0] key;
    logic           keyValid;
    logic [BB*8-1:0] plain;
    logic           start;
    logic [7:0]     txData;
    logic           txValid;
    logic           busy;
    logic           err;

    logic [7:0]     txq[$];
    int             startCount = 0;
    int             nChecks = 0;
    int             nFails = 0;
    logic [63:0]    expRes;
    logic [7:0]     expByte;

    always #5 clk = ~clk;

    tea_frame_frontend #(
        .KEY_BYTES      (KB),
        .BLOCK_BYTES    (BB),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rstN),
        .i_rx_data   (rxData),
        .i_rx_valid  (rxValid),
        .i_done      (done),
        .i_result    (result),
        .i_tx_ready  (txReady),
        .o_key       (key),
        .o_key_valid (keyValid),
        .o_plain     (plain),
        .o_start     (start),
        .o_tx_data   (txData),
        .o_tx_valid  (txValid),
        .o_busy      (busy),
        .o_err       (err)
    );

    // Record bytes that will transfer on the next rising edge, and count start pulses.
    always @(negedge clk) begin
        if (rstN && txValid && txReady) txq.push_back(txData);
        if (start) startCount++;
    end

    // Hard stop in case the sequence stalls somewhere unexpected.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    task automatic applyStimulus(input logic [7:0] b);
        @(posedge clk); #1;
        rxData  = b;
        rxValid = 1'b1;
        @(posedge clk); #1;
        rxValid = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        nChecks++;
        assert (observed === expected) else begin
            nFails++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic pulseDone(input logic [63:0] r);
        @(posedge clk); #1;
        done   = 1'b1;
        result = r;
        @(posedge clk); #1;
        done   = 1'b0;
        result = '0;
    endtask

    initial begin
        rstN    = 1'b0;
        rxData  = '0;
        rxValid = 1'b0;
        done    = 1'b0;
        result  = '0;
        txReady = 1'b1;

        // Reset state
        repeat (3) @(negedge clk);
        checkOutput("rst_key", key, 0);
        checkOutput("rst_key_valid", keyValid, 0);
        checkOutput("rst_plain", plain, 0);
        checkOutput("rst_start", start, 0);
        checkOutput("rst_tx_valid", txValid, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_err", err, 0);
        @(posedge clk); #1;
        rstN = 1'b1;

        // Plaintext command without a key, then clear; unknown command, then clear
        applyStimulus(8'h50);
        @(negedge clk);
        checkOutput("p_nokey_err", err, 1);
        checkOutput("p_nokey_busy", busy, 0);
        repeat (5) @(negedge clk);
        checkOutput("p_nokey_nostart", startCount, 0);
        applyStimulus(8'h43);
        @(negedge clk);
        checkOutput("clr_err", err, 0);
        applyStimulus(8'h99);
        @(negedge clk);
        checkOutput("badcmd_err", err, 1);
        applyStimulus(8'h43);
        @(negedge clk);
        checkOutput("clr2_err", err, 0);

        // Key frame 00..0F
        applyStimulus(8'h4B);
        for (int i = 0; i < 15; i++) applyStimulus(8'(i));
        @(negedge clk);
        checkOutput("key15_valid", keyValid, 0);
        checkOutput("key15_busy", busy, 1);
        applyStimulus(8'h0F);
        @(negedge clk);
        checkOutput("key_value", key, 128'h000102030405060708090A0B0C0D0E0F);
        checkOutput("key_valid", keyValid, 1);
        checkOutput("key_err", err, 0);
        checkOutput("key_busy", busy, 0);
        checkOutput("key_noack", txq.size(), 0);

        // Plaintext frame 01..08 with transmitter stalled
        txReady = 1'b0;
        applyStimulus(8'h50);
        for (int i = 1; i <= 8; i++) applyStimulus(8'(i));
        repeat (5) @(negedge clk);
        checkOutput("plain_value", plain, 64'h0102030405060708);
        checkOutput("start_once", startCount, 1);
        checkOutput("wait_busy", busy, 1);
        applyStimulus(8'h55);
        @(negedge clk);
        checkOutput("rx_in_wait_err", err, 1);
        checkOutput("rx_in_wait_busy", busy, 1);

        expRes = 64'hA1B2C3D4E5F60718;
        pulseDone(expRes);
        @(negedge clk);
        checkOutput("tx_first_valid", txValid, 1);
        checkOutput("tx_first_data", txData, 8'hA1);
        repeat (20) @(negedge clk);
        checkOutput("stall_data", txData, 8'hA1);
        checkOutput("stall_valid", txValid, 1);
        checkOutput("stall_nobytes", txq.size(), 0);
        @(posedge clk); #1;
        txReady = 1'b1;
        for (int c = 0; c < 100 && busy; c++) @(negedge clk);
        checkOutput("tx_finished", busy, 0);
        checkOutput("tx_count", txq.size(), 8);
        for (int i = 0; i < 8 && i < txq.size(); i++) begin
            expByte = expRes[63-8*i -: 8];
            checkOutput($sformatf("tx_byte%0d", i), txq[i], expByte);
        end
        checkOutput("tx_valid_after", txValid, 0);
        checkOutput("no_restart", startCount, 1);
        applyStimulus(8'h43);
        @(negedge clk);
        checkOutput("clr3_err", err, 0);

        // Reset in the middle of a transmission
        txq.delete();
        applyStimulus(8'h50);
        for (int i = 0; i < 8; i++) applyStimulus(8'h11 + 8'(i));
        repeat (3) @(negedge clk);
        pulseDone(64'h0011223344556677);
        for (int c = 0; c < 100 && txq.size() < 3; c++) begin
            @(negedge clk); #1;
        end
        checkOutput("pre_rst_count", txq.size(), 3);
        @(posedge clk); #1;
        rstN = 1'b0;
        #1;
        checkOutput("mid_rst_tx_valid", txValid, 0);
        checkOutput("mid_rst_tx_data", txData, 0);
        checkOutput("mid_rst_key", key, 0);
        checkOutput("mid_rst_key_valid", keyValid, 0);
        checkOutput("mid_rst_plain", plain, 0);
        checkOutput("mid_rst_busy", busy, 0);
        checkOutput("mid_rst_start", start, 0);
        checkOutput("mid_rst_err", err, 0);
        repeat (3) @(negedge clk);
        @(posedge clk); #1;
        rstN = 1'b1;
        repeat (20) @(negedge clk);
        checkOutput("post_rst_count", txq.size(), 3);
        checkOutput("post_rst_tx_valid", txValid, 0);
        if (txq.size() >= 3) begin
            checkOutput("rst_tx_byte0", txq[0], 8'h00);
            checkOutput("rst_tx_byte1", txq[1], 8'h11);
            checkOutput("rst_tx_byte2", txq[2], 8'h22);
        end

        // Inter-byte timeout during a second key frame
        applyStimulus(8'h4B);
        for (int i = 0; i < 16; i++) applyStimulus(8'hF0 + 8'(i));
        @(negedge clk);
        checkOutput("key2_value", key, 128'hF0F1F2F3F4F5F6F7F8F9FAFBFCFDFEFF);
        applyStimulus(8'h4B);
        for (int i = 0; i < 5; i++) applyStimulus(8'h11 + 8'(i));
        repeat (50) @(negedge clk);
        checkOutput("tmo_before_err", err, 0);
        checkOutput("tmo_before_busy", busy, 1);
        @(negedge clk);
        checkOutput("tmo_err", err, 1);
        checkOutput("tmo_busy", busy, 0);
        checkOutput("tmo_key_kept", key, 128'hF0F1F2F3F4F5F6F7F8F9FAFBFCFDFEFF);
        checkOutput("tmo_key_valid", keyValid, 1);
        applyStimulus(8'h43);
        @(negedge clk);
        checkOutput("clr4_err", err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
